// File: rtl/fig_rom_arb_pkg.sv
// Shared defaults for the figure-ROM arbiter.
// Define FIG_ROM_OUTREG_EN when the ROM is built with its output register (ROM_LAT = 2).
package fig_rom_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 11;
    localparam int DATA_W_DEF  = 8;

`ifdef FIG_ROM_OUTREG_EN
    localparam int ROM_LAT = 2;
`else
    localparam int ROM_LAT = 1;
`endif

endpackage

// File: rtl/fig_rr_arbiter.sv
// Combinational round-robin picker: the first requester found at or after ptr,
// wrapping modulo NUM_REQ, gets a one-hot grant.
module fig_rr_arbiter
    import fig_rom_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fig_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous figure ROM among NUM_REQ requesters.
// Response latency follows ROM_LAT, which FIG_ROM_OUTREG_EN raises to 2.
module fig_rom_arbiter
    import fig_rom_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rst,
    input  logic [DATA_W-1:0]         rom_rd_data,
    output logic                      idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [PTR_W-1:0]   tag_idx_q [ROM_LAT];
    logic [PTR_W-1:0]   tag_idx_d [ROM_LAT];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] req_gated, grant;
    logic [PTR_W-1:0]   gnt_idx;
    logic               accept;

    assign req_gated = en ? req_valid : '0;

    fig_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_gated),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        gnt_idx    = '0;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx    = PTR_W'(i);
                rom_addr_d = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        if (accept) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // The tag pipeline carries the granted index alongside the ROM read latency.
    always_comb begin
        tag_vld_d[0] = accept;
        tag_idx_d[0] = gnt_idx;
        for (int s = 1; s < ROM_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
        rsp_valid_d = '0;
        if (tag_vld_q[ROM_LAT-1]) begin
            rsp_valid_d[tag_idx_q[ROM_LAT-1]] = 1'b1;
        end
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rom_addr_q  <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rom_addr_q  <= rom_addr_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // NOTE: only the valid bits need reset; an index is never used while its valid is low.
    always_ff @(posedge clk) begin
        tag_idx_q <= tag_idx_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rom_rd_data;
    assign rom_addr  = rom_addr_q;
    assign rom_rst   = ~rst_n;
    assign idle      = ~|req_valid & ~|tag_vld_q;

endmodule

// File: doc/fig_rom_arbiter.md
FIG_ROM_ARBITER -- requirements
Module: fig_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the figure ROM (2..8).
REQ-002 SHALL have parameter ADDR_W, default 11, ROM address width.
REQ-003 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-004 SHALL have port clk  input  1  single clock for the arbiter and the ROM.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  grant enable; when low, no new grants are issued.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester read request.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant (combinational).
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe.
REQ-011 SHALL have port rsp_data  output  DATA_W  response data, equal to rom_rd_data.
REQ-012 SHALL have port rom_addr  output  ADDR_W  registered ROM address.
REQ-013 SHALL have port rom_rst  output  1  active-high ROM reset, equal to ~rst_n.
REQ-014 SHALL have port rom_rd_data  input  DATA_W  ROM read data.
REQ-015 SHALL have port idle  output  1  high when no read is in flight and no request is pending.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready is zero when en=0 or req_valid=0.
REQ-017 SHALL use round-robin priority: the search starts at ptr; after a grant to i, ptr becomes (i+1) mod NUM_REQ; ptr is held otherwise.
REQ-018 SHALL accept a request at edge N when req_valid[i] and req_ready[i] are both high; rom_addr loads req_addr[i] at N.
REQ-019 SHALL hold rom_addr when nothing is accepted.
REQ-020 SHALL track the granted index in a tag pipeline of depth ROM_LAT (1 by default).
REQ-021 SHALL assert rsp_valid[i] for exactly the one cycle following edge N+ROM_LAT, aligned with valid rom_rd_data.
REQ-022 SHALL sustain one accepted request per cycle with back-to-back grants and no bubbles.
REQ-023 SHALL leave acceptance by a requester unaffected by whether its req_valid is dropped after acceptance.
REQ-024 SHALL let in-flight reads complete normally when en falls; no new grants are issued.
REQ-025 SHALL drive idle = ~|req_valid & ~|tag pipeline valid bits.
REQ-026 SHALL wrap ptr from NUM_REQ-1 to 0.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force ptr=0, rom_addr=0, all tag valids=0, rsp_valid=0 and rom_rst=1.
REQ-028 SHALL discard reads in flight when reset asserts mid-operation, with no rsp_valid after release.
REQ-029 SHALL issue its first grant no earlier than the first edge after rst_n rises.

Configuration
REQ-030 SHALL support macro FIG_ROM_OUTREG_EN; when defined, ROM_LAT=2, matching a ROM built with its output register, and rsp_valid follows edge N+2.
REQ-031 SHALL use ROM_LAT=1 when FIG_ROM_OUTREG_EN is undefined.

Structure
REQ-032 SHALL take NUM_REQ_DEF, ADDR_W_DEF, DATA_W_DEF and ROM_LAT from shared package fig_rom_arb_pkg, with ROM_LAT set there from the macro.
REQ-033 SHALL put round-robin grant logic in sub-module fig_rr_arbiter (inputs req, ptr; output one-hot grant); tag pipeline and address register stay in the top.

Verification
Bench ROM model: data = addr[7:0] ^ 8'hA5, latency ROM_LAT.
REQ-034 SHALL verify: req_valid=4'b0100, addr2=11'h123 accepted at edge N -> rsp_valid=4'b0100 after N+1, rsp_data=8'h86.
REQ-035 SHALL verify: all four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses, one per cycle, data correct.
REQ-036 SHALL verify: en=0 with req_valid=4'hF -> req_ready=0 and idle=0; en rises -> requester ptr is granted in the same cycle.
REQ-037 SHALL verify: rst_n pulled low one cycle after an accept -> rsp_valid stays 0, rom_addr=0, rom_rst=1; after release, first grant goes to requester 0.
REQ-038 SHALL verify: addr=11'h7FF from requester 3 followed by requester 0 -> ptr wraps to 0 and responses are 8'h5A then correct data.
REQ-039 SHALL verify: FIG_ROM_OUTREG_EN defined -> all above pass with response one cycle later.
